// File: rtl/formation_pkg.sv
// Shared types and width helpers for the alien formation movement blocks.
package formation_pkg;

    localparam int PIX_W  = 11;
    localparam int EDGE_W = 11;

    typedef enum logic [2:0] {
        S_RIGHT,
        S_DOWN_TO_LEFT,
        S_LEFT,
        S_DOWN_TO_RIGHT,
        S_LANDED
    } state_t;

    function automatic int alive_w(input int num_aliens);
        return $clog2(num_aliens + 1);
    endfunction

    function automatic int pos_w(input int fp_shift);
        return PIX_W + fp_shift;
    endfunction

endpackage

// File: rtl/formation_speed_calc.sv
// Registered per-frame speed: faster as aliens die, optional turbo, saturated.
module formation_speed_calc
    import formation_pkg::*;
#(
    parameter int unsigned NUM_ALIENS  = 40,
    parameter int unsigned BASE_SPEED  = 64,
    parameter int unsigned SPEED_STEP  = 4,
    parameter int unsigned MAX_SPEED   = 1024,
    parameter int unsigned TURBO_SHIFT = 3,
    parameter int unsigned ALIVE_W     = 6,
    parameter int unsigned SPEED_W     = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    input  logic               turbo,
    input  logic [ALIVE_W-1:0] aliveCount,
    output logic [SPEED_W-1:0] speed
);

    logic [31:0]        alive_c;
    logic [31:0]        raw;
    logic [SPEED_W-1:0] speed_d;

    always_comb begin
        alive_c = 32'(aliveCount);
        if (alive_c > NUM_ALIENS) begin
            alive_c = NUM_ALIENS;
        end
        raw = BASE_SPEED + (NUM_ALIENS - alive_c) * SPEED_STEP;
        if (turbo) begin
            raw = raw << TURBO_SHIFT;
        end
        if (raw > MAX_SPEED) begin
            raw = MAX_SPEED;
        end
        speed_d = SPEED_W'(raw);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            speed <= SPEED_W'(BASE_SPEED);
        end else if (restart) begin
            speed <= SPEED_W'(BASE_SPEED);
        end else begin
            speed <= speed_d;
        end
    end

endmodule

// File: rtl/formation_mover.sv
// Per-frame formation position generator: horizontal sweep, step-down at edges,
// landing detection. Position kept in signed fixed point, outputs in pixels.
module formation_mover
    import formation_pkg::*;
#(
    parameter int          FP_SHIFT     = 6,
    parameter int          INIT_X       = 40,
    parameter int          INIT_Y       = 40,
    parameter int          LEFT_LIMIT   = 40,
    parameter int          RIGHT_LIMIT  = 599,
    parameter int          BOTTOM_LIMIT = 400,
    parameter int          Y_GAP        = 8,
    parameter int unsigned NUM_ALIENS   = 40,
    parameter int unsigned BASE_SPEED   = 64,
    parameter int unsigned SPEED_STEP   = 4,
    parameter int unsigned MAX_SPEED    = 1024,
    parameter int unsigned TURBO_SHIFT  = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             startOfFrame,
    input  logic                             restart,
    input  logic                             freeze,
    input  logic                             turbo,
    input  logic [alive_w(NUM_ALIENS)-1:0]   aliveCount,
    input  logic [EDGE_W-1:0]                leftMargin,
    input  logic [EDGE_W-1:0]                rightSpan,
    output logic signed [PIX_W-1:0]          topLeftX,
    output logic signed [PIX_W-1:0]          topLeftY,
    output logic                             movingLeft,
    output logic                             landed,
    output logic                             stepPulse
);

    localparam int POS_W   = pos_w(FP_SHIFT);
    localparam int SPEED_W = $clog2(MAX_SPEED + 1);
    localparam int ALIVE_W = alive_w(NUM_ALIENS);

    localparam logic signed [POS_W-1:0] X_RESET = POS_W'(INIT_X <<< FP_SHIFT);
    localparam logic signed [POS_W-1:0] Y_RESET = POS_W'(INIT_Y <<< FP_SHIFT);
    localparam logic signed [POS_W-1:0] Y_STEP  = POS_W'(Y_GAP <<< FP_SHIFT);

    state_t                   state;
    logic signed [POS_W-1:0]  x_q, y_q, tgt_q;
    logic [SPEED_W-1:0]       speed;

    logic signed [POS_W-1:0]  speed_s, nx_r, nx_l, ny, tgt_new, x_clamp_r, x_clamp_l;
    logic signed [31:0]       nx_r_pix, nx_l_pix, span_s, margin_s, tgt_pix;
    logic                     hit_r, hit_l, tgt_lands, y_reached, update;

    formation_speed_calc #(
        .NUM_ALIENS  (NUM_ALIENS),
        .BASE_SPEED  (BASE_SPEED),
        .SPEED_STEP  (SPEED_STEP),
        .MAX_SPEED   (MAX_SPEED),
        .TURBO_SHIFT (TURBO_SHIFT),
        .ALIVE_W     (ALIVE_W),
        .SPEED_W     (SPEED_W)
    ) u_speed (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .turbo      (turbo),
        .aliveCount (aliveCount),
        .speed      (speed)
    );

    always_comb begin
        speed_s   = $signed({{(POS_W - SPEED_W){1'b0}}, speed});
        span_s    = $signed({{(32 - EDGE_W){1'b0}}, rightSpan});
        margin_s  = $signed({{(32 - EDGE_W){1'b0}}, leftMargin});
        nx_r      = x_q + speed_s;
        nx_l      = x_q - speed_s;
        nx_r_pix  = 32'(nx_r >>> FP_SHIFT);
        nx_l_pix  = 32'(nx_l >>> FP_SHIFT);
        hit_r     = (nx_r_pix + span_s) > RIGHT_LIMIT;
        hit_l     = (nx_l_pix + margin_s) < LEFT_LIMIT;
        x_clamp_r = POS_W'((RIGHT_LIMIT - span_s) <<< FP_SHIFT);
        x_clamp_l = POS_W'((LEFT_LIMIT - margin_s) <<< FP_SHIFT);
        tgt_new   = y_q + Y_STEP;
        tgt_pix   = 32'(tgt_new >>> FP_SHIFT);
        tgt_lands = tgt_pix >= BOTTOM_LIMIT;
        ny        = y_q + speed_s;
        y_reached = ny >= tgt_q;
        update    = startOfFrame && !freeze && !restart && (state != S_LANDED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_RIGHT;
            x_q        <= X_RESET;
            y_q        <= Y_RESET;
            tgt_q      <= Y_RESET;
            movingLeft <= 1'b0;
            landed     <= 1'b0;
            stepPulse  <= 1'b0;
        end else if (restart) begin
            state      <= S_RIGHT;
            x_q        <= X_RESET;
            y_q        <= Y_RESET;
            tgt_q      <= Y_RESET;
            movingLeft <= 1'b0;
            landed     <= 1'b0;
            stepPulse  <= 1'b0;
        end else begin
            stepPulse <= update;
            if (update) begin
                case (state)
                    S_RIGHT: begin
                        if (hit_r) begin
                            x_q   <= x_clamp_r;
                            tgt_q <= tgt_new;
                            // Landing is decided at the edge; Y never moves toward the floor.
                            if (tgt_lands) begin
                                state  <= S_LANDED;
                                landed <= 1'b1;
                            end else begin
                                state <= S_DOWN_TO_LEFT;
                            end
                        end else begin
                            x_q <= nx_r;
                        end
                    end
                    S_LEFT: begin
                        if (hit_l) begin
                            x_q   <= x_clamp_l;
                            tgt_q <= tgt_new;
                            if (tgt_lands) begin
                                state  <= S_LANDED;
                                landed <= 1'b1;
                            end else begin
                                state <= S_DOWN_TO_RIGHT;
                            end
                        end else begin
                            x_q <= nx_l;
                        end
                    end
                    S_DOWN_TO_LEFT: begin
                        if (y_reached) begin
                            y_q        <= tgt_q;
                            state      <= S_LEFT;
                            movingLeft <= 1'b1;
                        end else begin
                            y_q <= ny;
                        end
                    end
                    S_DOWN_TO_RIGHT: begin
                        if (y_reached) begin
                            y_q        <= tgt_q;
                            state      <= S_RIGHT;
                            movingLeft <= 1'b0;
                        end else begin
                            y_q <= ny;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign topLeftX = PIX_W'(x_q >>> FP_SHIFT);
    assign topLeftY = PIX_W'(y_q >>> FP_SHIFT);

endmodule

// File: tb/tb_formation_mover.sv
// Self-checking bench for formation_mover against a pixel/fixed-point motion model.
module tb_formation_mover;

    localparam int FP     = 6;
    localparam int ONE    = 1 << FP;
    localparam int INITX  = 40;
    localparam int INITY  = 40;
    localparam int LEFTL  = 40;
    localparam int RIGHTL = 599;
    localparam int BOTTOM = 400;
    localparam int GAP    = 8;
    localparam int NUM    = 40;
    localparam int BASE   = 64;
    localparam int STEP   = 4;
    localparam int MAXS   = 1024;
    localparam int TSH    = 3;

    logic clk = 1'b0;
    logic reset, sof, restart, freeze, turbo;
    logic [5:0] alive;
    logic [10:0] lm, rs;
    logic signed [10:0] tlx, tly;
    logic ml, landed, step;

    int total = 0;
    int bad   = 0;
    int pulses;

    // Model: fixed-point position, direction (+1/-1), descending flag, target row.
    int mx, my, mtgt, mdir, mdesc, mland, mspd, mpulse;

    always #5 clk = ~clk;

    formation_mover dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (sof),
        .restart      (restart),
        .freeze       (freeze),
        .turbo        (turbo),
        .aliveCount   (alive),
        .leftMargin   (lm),
        .rightSpan    (rs),
        .topLeftX     (tlx),
        .topLeftY     (tly),
        .movingLeft   (ml),
        .landed       (landed),
        .stepPulse    (step)
    );

    task automatic model_reset();
        mx = INITX * ONE; my = INITY * ONE; mtgt = my;
        mdir = 1; mdesc = 0; mland = 0; mspd = BASE; mpulse = 0;
    endtask

    function automatic int calc_speed();
        int a, s;
        a = int'(alive);
        if (a > NUM) a = NUM;
        s = BASE + (NUM - a) * STEP;
        if (turbo) s = s << TSH;
        if (s > MAXS) s = MAXS;
        return s;
    endfunction

    task automatic model_frame();
        int nx, r, m;
        r = int'(rs);
        m = int'(lm);
        if (mdesc != 0) begin
            my = my + mspd;
            if (my >= mtgt) begin
                my = mtgt; mdesc = 0; mdir = -mdir;
            end
        end else begin
            nx = mx + mdir * mspd;
            if ((mdir > 0 && (nx >>> FP) + r > RIGHTL) || (mdir < 0 && (nx >>> FP) + m < LEFTL)) begin
                mx = (mdir > 0) ? (RIGHTL - r) * ONE : (LEFTL - m) * ONE;
                mtgt = my + GAP * ONE;
                if ((mtgt >>> FP) >= BOTTOM) mland = 1;
                else mdesc = 1;
            end else begin
                mx = nx;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset || restart) begin
            model_reset();
        end else begin
            mpulse = (sof && !freeze && mland == 0) ? 1 : 0;
            if (mpulse != 0) model_frame();
            mspd = calc_speed();
        end
        #1;
        if (step) pulses++;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            sof = 1'b1; tick();
            sof = 1'b0; tick();
        end
    endtask

    task automatic do_restart();
        restart = 1'b1; tick(); restart = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; sof = 0; restart = 0; freeze = 0; turbo = 0;
        alive = 6'd40; lm = 11'd0; rs = 11'd448;
        model_reset();
        #1;
        total++;
        if (tlx !== 11'sd40 || tly !== 11'sd40 || ml !== 1'b0 || landed !== 1'b0 || step !== 1'b0) begin
            bad++;
            $display("FAIL reset: got x=%0d y=%0d ml=%b ld=%b sp=%b, want 40 40 0 0 0",
                     tlx, tly, ml, landed, step);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_sweep();
        pulses = 0;
        frames(10);
        total++;
        if (tlx !== 11'sd50 || tly !== 11'sd40 || pulses != 10) begin
            bad++;
            $display("FAIL sweep10: got x=%0d y=%0d pulses=%0d, want 50 40 10", tlx, tly, pulses);
        end
        frames(102);
        total++;
        if (tlx !== 11'sd151 || tly !== 11'sd40 || ml !== 1'b0 || mdesc != 1) begin
            bad++;
            $display("FAIL edge_clamp: got x=%0d y=%0d ml=%b, want 151 40 0", tlx, tly, ml);
        end
        frames(7);
        total++;
        if (tly !== 11'sd47 || ml !== 1'b0) begin
            bad++;
            $display("FAIL descend7: got y=%0d ml=%b, want 47 0", tly, ml);
        end
        frames(1);
        total++;
        if (tly !== 11'sd48 || ml !== 1'b1 || tlx !== 11'sd151) begin
            bad++;
            $display("FAIL descend_done: got x=%0d y=%0d ml=%b, want 151 48 1", tlx, tly, ml);
        end
    endtask

    task automatic test_speed();
        logic signed [10:0] x0;
        do_restart();
        alive = 6'd0; rs = 11'd448; lm = 11'd0; turbo = 1'b0;
        tick();
        frames(1);
        total++;
        if (tlx !== 11'sd43 || tlx !== 11'(mx >>> FP)) begin
            bad++;
            $display("FAIL speed224: got x=%0d, want 43", tlx);
        end
        turbo = 1'b1;
        tick();
        x0 = tlx;
        frames(1);
        total++;
        if (tlx - x0 !== 11'sd16 || tlx !== 11'(mx >>> FP)) begin
            bad++;
            $display("FAIL turbo_sat: got dx=%0d x=%0d, want dx=16 x=%0d", tlx - x0, tlx, mx >>> FP);
        end
        turbo = 1'b0;
    endtask

    task automatic test_landed();
        logic signed [10:0] x0, y0;
        do_restart();
        turbo = 1'b1; alive = 6'd0; rs = 11'd500; lm = 11'd0;
        for (int i = 0; i < 3000 && mland == 0; i++) frames(1);
        total++;
        if (landed !== 1'b1 || mland == 0 || tly !== 11'sd392 || tlx !== 11'(mx >>> FP)) begin
            bad++;
            $display("FAIL land: got ld=%0d x=%0d y=%0d, want 1 %0d 392", landed, tlx, tly, mx >>> FP);
        end
        x0 = tlx; y0 = tly; pulses = 0;
        frames(5);
        total++;
        if (pulses != 0 || tlx !== x0 || tly !== y0 || landed !== 1'b1) begin
            bad++;
            $display("FAIL land_frozen: got pulses=%0d x=%0d y=%0d, want 0 %0d %0d",
                     pulses, tlx, tly, x0, y0);
        end
        do_restart();
        total++;
        if (tlx !== 11'sd40 || tly !== 11'sd40 || landed !== 1'b0 || ml !== 1'b0) begin
            bad++;
            $display("FAIL land_restart: got x=%0d y=%0d ld=%b ml=%b, want 40 40 0 0",
                     tlx, tly, landed, ml);
        end
        turbo = 1'b0;
    endtask

    task automatic test_freeze();
        logic signed [10:0] x0, y0;
        alive = 6'd40; rs = 11'd448;
        frames(3);
        freeze = 1'b1; pulses = 0; x0 = tlx; y0 = tly;
        frames(5);
        total++;
        if (pulses != 0 || tlx !== x0 || tly !== y0) begin
            bad++;
            $display("FAIL freeze: got pulses=%0d x=%0d y=%0d, want 0 %0d %0d", pulses, tlx, tly, x0, y0);
        end
        freeze = 1'b0;
        frames(2);
        restart = 1'b1; sof = 1'b1; tick();
        restart = 1'b0; sof = 1'b0;
        total++;
        if (tlx !== 11'sd40 || tly !== 11'sd40 || step !== 1'b0 || landed !== 1'b0) begin
            bad++;
            $display("FAIL restart_vs_sof: got x=%0d y=%0d sp=%b, want 40 40 0", tlx, tly, step);
        end
    endtask

    task automatic test_reset_mid();
        frames(6);
        reset = 1'b1;
        #1;
        total++;
        if (tlx !== 11'sd40 || tly !== 11'sd40 || ml !== 1'b0 || landed !== 1'b0 || step !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got x=%0d y=%0d ml=%b ld=%b sp=%b, want 40 40 0 0 0",
                     tlx, tly, ml, landed, step);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [24:0] got, exp;
        int errs = 0;
        for (int c = 0; c < 4000; c++) begin
            sof     = ($urandom_range(0, 2) == 0);
            freeze  = ($urandom_range(0, 7) == 0);
            restart = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) turbo = $urandom_range(0, 1) != 0;
            alive = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 63) == 0) rs = 11'($urandom_range(300, 540));
            if ($urandom_range(0, 63) == 0) lm = 11'($urandom_range(0, 30));
            tick();
            got = {tlx, tly, ml, landed, step};
            exp = {11'(mx >>> FP), 11'(my >>> FP), mdir < 0, mland != 0, mpulse != 0};
            total++;
            if (got !== exp) begin
                bad++;
                if (errs < 10)
                    $display("FAIL random[%0d]: got x=%0d y=%0d ml=%b ld=%b sp=%b, want %0d %0d %b %b %b",
                             c, tlx, tly, ml, landed, step, exp[24:14], exp[13:3], exp[2], exp[1], exp[0]);
                errs++;
            end
        end
        sof = 0; freeze = 0; restart = 0; turbo = 0;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_speed();
        test_landed();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
